instr_fetch_unit: RTL

Instruction fetch front end that feeds the decode stage. Keeps the program counter and issues word reads to a synchronous instruction memory. Buffers returned words in a small prefetch FIFO. Presents them to the decoder over the instruction_data / instruction_RDY_BSY ↔ decoder_rdy_bsy handshake, and supports PC redirect with flush.

---
 rtl/instr_fetch_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, imem read issue, prefetch FIFO and decoder handshake.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          IMEM_AW    = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_enable,
  output logic               imem_rd_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instruction_data,
  output logic [31:0]        instruction_pc,
  output logic               instruction_RDY_BSY,
  input  logic               decoder_rdy_bsy,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               rd_en_q, rd_en_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic               inflight_q, inflight_d;
  logic [31:0]        infl_pc_q, infl_pc_d;
  logic [31:0]        mem_data_q [FIFO_DEPTH];
  logic [31:0]        mem_data_d [FIFO_DEPTH];
  logic [31:0]        mem_pc_q [FIFO_DEPTH];
  logic [31:0]        mem_pc_d [FIFO_DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               out_vld_q, out_vld_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [31:0]        out_pc_q, out_pc_d;
  logic               transfer;
  logic               push;
  logic [CW:0]        occ_next;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        perf_fetch_q, perf_fetch_d;
  logic [31:0]        perf_stall_q, perf_stall_d;
`endif

  // Next-state logic for FSM, PC, in-flight tracking and FIFO
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = 1'b0;
    infl_pc_d  = infl_pc_q;
    mem_data_d = mem_data_q;
    mem_pc_d   = mem_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_pc_d   = out_pc_q;

    transfer = out_vld_q & decoder_rdy_bsy;
    push     = inflight_q & ~redirect_valid;

    case (state_q)
      IDLE:    state_d = fetch_enable ? RUN : IDLE;
      RUN:     state_d = fetch_enable ? RUN : IDLE;
      FLUSH:   state_d = fetch_enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    // A redirect lets the same-cycle transfer complete, then drops everything queued
    if (redirect_valid) begin
      state_d    = FLUSH;
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      inflight_d = 1'b0;
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
      out_vld_d  = 1'b0;
    end else begin
      if (rd_en_q) begin
        pc_d       = pc_q + 32'd4;
        inflight_d = 1'b1;
        infl_pc_d  = pc_q;
      end else begin
        inflight_d = 1'b0;
      end
      if (push) begin
        mem_data_d[wr_ptr_q] = imem_rdata;
        mem_pc_d[wr_ptr_q]   = infl_pc_q;
        wr_ptr_d             = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (transfer) begin
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d   = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, transfer};
      out_vld_d = (count_d != {CW{1'b0}});
      if (out_vld_d) begin
        out_data_d = mem_data_d[rd_ptr_d];
        out_pc_d   = mem_pc_d[rd_ptr_d];
      end else begin
        out_data_d = out_data_q;
        out_pc_d   = out_pc_q;
      end
    end

    // Reads already in flight count against capacity so the FIFO can never overflow
    occ_next = {1'b0, count_d} + {{CW{1'b0}}, inflight_d};
    rd_en_d  = (state_d == RUN) && (occ_next < (CW+1)'(FIFO_DEPTH));
    addr_d   = pc_d[IMEM_AW+1:2];
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counter next values
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (transfer) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end else begin
      perf_fetch_d = perf_fetch_q;
    end
    if (decoder_rdy_bsy && !out_vld_q && (state_q != IDLE)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

  // State, PC, FIFO and registered output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      rd_en_q    <= 1'b0;
      addr_q     <= {IMEM_AW{1'b0}};
      inflight_q <= 1'b0;
      infl_pc_q  <= 32'h0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= 32'h0;
        mem_pc_q[i]   <= 32'h0;
      end
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      out_vld_q  <= 1'b0;
      out_data_q <= 32'h0;
      out_pc_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      infl_pc_q  <= infl_pc_d;
      mem_data_q <= mem_data_d;
      mem_pc_q   <= mem_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_pc_q   <= out_pc_d;
    end
  end

  assign imem_rd_en          = rd_en_q;
  assign imem_addr           = addr_q;
  assign instruction_data    = out_data_q;
  assign instruction_pc      = out_pc_q;
  assign instruction_RDY_BSY = out_vld_q;

endmodule
